// File: rtl/bla_pkg.sv
// Shared constants and stage-register record for the pipelined 16-bit
// borrow-lookahead subtractor.
package bla_pkg;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned SLICE   = 4;
  localparam int unsigned NSTAGES = 4;

  // a_rem/b_rem are shifted right one slice per stage so the next slice is
  // always at bits [SLICE-1:0]; diff fills from the top and lands aligned
  // after the last stage.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             a_msb;
    logic             b_msb;
  } stage_t;

endpackage

// File: rtl/bla4_slice.sv
// 4-bit subtract slice with full borrow lookahead (no ripple chain).
module bla4_slice
  import bla_pkg::*;
(
  input  logic [SLICE-1:0] a4,
  input  logic [SLICE-1:0] b4,
  input  logic             bin,
  output logic [SLICE-1:0] d4,
  output logic             bout
);

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE:0]   br;

  // Borrow generate when a=0,b=1; propagate when a==b.
  always_comb begin
    g     = ~a4 & b4;
    p     = ~(a4 ^ b4);
    br[0] = bin;
    br[1] = g[0] | (p[0] & bin);
    br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
          | (p[2] & p[1] & p[0] & bin);
    br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bin);
    d4    = a4 ^ b4 ^ br[SLICE-1:0];
    bout  = br[SLICE];
  end

endmodule

// File: rtl/bla_sub16_pipe.sv
// Four-stage pipelined 16-bit subtractor (a - b - bin), one 4-bit lookahead
// slice per stage, valid/ready handshake with global stall.
module bla_sub16_pipe
  import bla_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  stage_t           st   [NSTAGES];
  stage_t           src  [NSTAGES];
  stage_t           nxt  [NSTAGES];
  logic [SLICE-1:0] a4_s [NSTAGES];
  logic [SLICE-1:0] b4_s [NSTAGES];
  logic [SLICE-1:0] d4_s [NSTAGES];
  logic             bin_s  [NSTAGES];
  logic             bout_s [NSTAGES];
  logic             advance;

  // Whole pipe moves together; it only holds when the result is blocked.
  assign advance  = out_ready | ~st[NSTAGES-1].valid;
  assign in_ready = advance;

  always_comb begin
    src[0].valid  = in_valid;
    src[0].a_rem  = a;
    src[0].b_rem  = b;
    src[0].diff   = '0;
    src[0].borrow = bin;
    src[0].a_msb  = a[WIDTH-1];
    src[0].b_msb  = b[WIDTH-1];
    for (int k = 1; k < int'(NSTAGES); k++) begin
      src[k] = st[k-1];
    end
    for (int k = 0; k < int'(NSTAGES); k++) begin
      a4_s[k]  = src[k].a_rem[SLICE-1:0];
      b4_s[k]  = src[k].b_rem[SLICE-1:0];
      bin_s[k] = src[k].borrow;
    end
  end

  for (genvar k = 0; k < int'(NSTAGES); k++) begin : g_slice
    bla4_slice u_slice (
      .a4   (a4_s[k]),
      .b4   (b4_s[k]),
      .bin  (bin_s[k]),
      .d4   (d4_s[k]),
      .bout (bout_s[k])
    );
  end

  always_comb begin
    for (int k = 0; k < int'(NSTAGES); k++) begin
      nxt[k]        = src[k];
      nxt[k].a_rem  = src[k].a_rem >> SLICE;
      nxt[k].b_rem  = src[k].b_rem >> SLICE;
      nxt[k].diff   = {d4_s[k], src[k].diff[WIDTH-1:SLICE]};
      nxt[k].borrow = bout_s[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NSTAGES); k++) begin
        st[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < int'(NSTAGES); k++) begin
        st[k] <= nxt[k];
      end
    end
  end

  assign out_valid = st[NSTAGES-1].valid;
  assign diff      = st[NSTAGES-1].diff;
  assign bout      = st[NSTAGES-1].borrow;
  assign ovf       = (st[NSTAGES-1].a_msb ^ st[NSTAGES-1].b_msb)
                   & (st[NSTAGES-1].diff[WIDTH-1] ^ st[NSTAGES-1].a_msb);

endmodule

// File: tb/tb_bla_sub16_pipe.sv
// Directed and randomized checks of the pipelined 16-bit subtractor.
module tb_bla_sub16_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bla_sub16_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1; a = 16'h1111; b = 16'h0001; bin = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL reset_diff: got %h expected 0000", diff); end
    checks++; if ({bout, ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {bout, ovf}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    // First transfer on the first edge after release.
    rst_n = 1'b1; a = 16'h0005; b = 16'h0003; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL first_latency_early: got %b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b expected 1", out_valid); end
    checks++; if ({ovf, bout, diff} !== {1'b0, 1'b0, 16'h0002}) begin
      errors++; $display("FAIL first_result: got ovf=%b bout=%b diff=%h expected 0 0 0002", ovf, bout, diff);
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL first_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_basic;
    logic [15:0] va [7] = '{16'h0000, 16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0F0F, 16'h0005};
    logic [15:0] vb [7] = '{16'h0001, 16'h1234, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h00F0, 16'h0003};
    logic        vc [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] ed [7] = '{16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0E1F, 16'h0001};
    logic        eb [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        eo [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a = va[i]; b = vb[i]; bin = vc[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (2) tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early[%0d]: got %b expected 0", i, out_valid); end
      tick();
      checks++; if ({out_valid, ovf, bout, diff} !== {1'b1, eo[i], eb[i], ed[i]}) begin
        errors++;
        $display("FAIL basic[%0d]: got v=%b ovf=%b bout=%b diff=%h expected 1 %b %b %h",
                 i, out_valid, ovf, bout, diff, eo[i], eb[i], ed[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] va [4] = '{16'h0010, 16'h0001, 16'h1000, 16'hABCD};
    logic [15:0] vb [4] = '{16'h0001, 16'h0002, 16'h0001, 16'h1111};
    logic        vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] ed [4] = '{16'h000F, 16'hFFFF, 16'h0FFE, 16'h9ABC};
    logic        eb [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = va[i]; b = vb[i]; bin = vc[i]; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", c, in_ready); end
      checks++; if ({out_valid, bout, diff} !== {1'b1, eb[0], ed[0]}) begin
        errors++; $display("FAIL stall_frozen[%0d]: got v=%b bout=%b diff=%h expected 1 %b %h", c, out_valid, bout, diff, eb[0], ed[0]);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if ({out_valid, bout, diff} !== {1'b1, eb[k], ed[k]}) begin
        errors++; $display("FAIL b2b_order[%0d]: got v=%b bout=%b diff=%h expected 1 %b %h", k, out_valid, bout, diff, eb[k], ed[k]);
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_midflight;
    int stale = 0;
    out_ready = 1'b1;
    a = 16'h4444; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
    tick();
    a = 16'h9999; b = 16'h0009;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    checks++; if ({out_valid, diff} !== {1'b1, 16'h3333}) begin
      errors++; $display("FAIL midrst_pre: got v=%b diff=%h expected 1 3333", out_valid, diff);
    end
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, bout, ovf, diff} !== 19'h0) begin
      errors++; $display("FAIL midrst_async: got v=%b bout=%b ovf=%b diff=%h expected all 0", out_valid, bout, ovf, diff);
    end
    in_valid = 1'b1; a = 16'h7777;
    repeat (2) tick();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL midrst_stale: got %0d valid cycles expected 0", stale); end
  endtask

  task automatic test_random;
    localparam int N = 10000;
    logic [17:0] q[$];
    logic [17:0] obs, snap, expv;
    logic [16:0] r;
    logic        stall_prev = 1'b0;
    logic        m_ovf;
    int sent = 0, got = 0, cyc = 0;
    snap = '0;
    while ((sent < N || got < sent) && cyc < 60000) begin
      in_valid  = (sent < N) && ($urandom_range(0, 3) != 0);
      a         = 16'($urandom);
      b         = 16'($urandom);
      bin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      obs = {ovf, bout, diff};
      if (stall_prev) begin
        checks++; if (out_valid !== 1'b1 || obs !== snap) begin
          errors++; $display("FAIL rand_stall_hold: got v=%b %h expected 1 %h", out_valid, obs, snap);
        end
      end
      checks++; if (in_ready !== (out_ready | ~out_valid)) begin
        errors++; $display("FAIL rand_in_ready: got %b expected %b", in_ready, out_ready | ~out_valid);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_unexpected: got %h expected no result", obs);
        end else begin
          expv = q.pop_front();
          got++;
          if (obs !== expv) begin
            errors++; $display("FAIL rand_result[%0d]: got ovf/bout/diff %h expected %h", got, obs, expv);
          end
        end
      end
      if (in_valid && in_ready) begin
        r = {1'b0, a} - {1'b0, b} - 17'(bin);
        m_ovf = (a[15] != b[15]) && (r[15] != a[15]);
        q.push_back({m_ovf, r[16], r[15:0]});
        sent++;
      end
      stall_prev = out_valid && !out_ready;
      snap = obs;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (sent != N || got != N || q.size() != 0) begin
      errors++; $display("FAIL rand_complete: got sent=%0d received=%0d pending=%0d expected %0d %0d 0", sent, got, q.size(), N, N);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bla_sub16_pipe.md
BLA_SUB16_PIPE -- requirements
Module: bla_sub16_pipe

Interface
REQ-001 The block SHALL have no parameters; width 16, slice 4 and depth 4 are fixed constants.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operand transfer request.
REQ-005 in_ready  output  1  block can accept operands this cycle.
REQ-006 a  input  16  minuend, bit 0 = LSB.
REQ-007 b  input  16  subtrahend, bit 0 = LSB.
REQ-008 bin  input  1  borrow-in.
REQ-009 out_valid  output  1  result present on diff/bout/ovf.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 diff  output  16  a - b - bin, modulo 2^16.
REQ-012 bout  output  1  unsigned borrow-out: 1 iff a < b + bin.
REQ-013 ovf  output  1  two's-complement overflow: (a[15] != b[15]) and (diff[15] != a[15]).

Function
REQ-014 Per bit, the block SHALL compute borrow-generate g = ~a & b, borrow-propagate p = ~(a ^ b), diff = a ^ b ^ borrow_in.
REQ-015 Within a slice, borrows SHALL use full lookahead (b1..b4 as sum-of-products of g, p and slice borrow-in), with no ripple chain.
REQ-016 Stage k (k = 0..3) SHALL compute slice bits [4k+3:4k] and register the slice borrow-out as the next stage's borrow-in.
REQ-017 Each stage SHALL carry the not-yet-processed upper operand bits, the completed lower diff bits, a[15]/b[15] and a valid bit.
REQ-018 A transfer SHALL occur when in_valid and in_ready are both 1; its result SHALL appear on out_valid exactly 4 cycles later when no stall occurs.
REQ-019 Throughput SHALL be one operation per cycle while out_ready stays 1.
REQ-020 Stall SHALL be out_valid and not out_ready; during a stall, all stage registers hold and in_ready = 0.
REQ-021 in_ready SHALL equal (out_ready or not out_valid), combinationally.
REQ-022 While out_valid is 1 and out_ready is 0, diff, bout and ovf SHALL stay stable.
REQ-023 Results SHALL emerge in acceptance order, with none dropped or duplicated.
REQ-024 Bubbles (in_valid = 0) SHALL propagate as invalid stages and SHALL NOT be collapsed.
REQ-025 Wrap-around SHALL be modulo 2^16 with no saturation; bout and ovf are the only range indicators.

Reset
REQ-026 While rst_n = 0, all stage valid bits, out_valid, diff, bout and ovf SHALL be 0, asynchronously.
REQ-027 Operands presented while rst_n = 0 SHALL be ignored.
REQ-028 Reset asserted mid-operation SHALL discard every in-flight operation; no stale result may appear after release.
REQ-029 The first transfer SHALL be possible in the first clock edge after rst_n deasserts.

Structure
REQ-030 A shared package bla_pkg SHALL hold WIDTH = 16, SLICE = 4 and NSTAGES = 4, plus the stage-register record typedef.
REQ-031 One combinational sub-module bla4_slice (inputs a4, b4, bin; outputs d4, bout) SHALL be instantiated once per stage.
REQ-032 Only the stage registers SHALL be sequential; no state exists outside the pipeline.

Verification
REQ-033 a = 0x0005, b = 0x0003, bin = 0 -> 4 cycles later: diff = 0x0002, bout = 0, ovf = 0.
REQ-034 a = 0x0000, b = 0x0001, bin = 0 -> diff = 0xFFFF, bout = 1, ovf = 0; a = 0x1234, b = 0x1234, bin = 1 -> diff = 0xFFFF, bout = 1.
REQ-035 a = 0x8000, b = 0x0001, bin = 0 -> diff = 0x7FFF, bout = 0, ovf = 1.
REQ-036 Four back-to-back ops, then out_ready = 0 for 3 cycles:
- in_ready = 0 throughout the stall;
- outputs stay frozen;
- all four results arrive in order afterwards.
REQ-037 rst_n pulsed low with 2 ops in flight:
- out_valid = 0 immediately;
- neither op's result appears after release.
REQ-038 10,000 random a/b/bin with random in_valid/out_ready -> every result matches the reference model a - b - bin, including bout and ovf.
